hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MD_LAT, default 32, multiply/divide latency in cycles, legal range 2..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 id_rs  input  5  rs field of the instruction in ID.
REQ-005 id_rt  input  5  rt field of the instruction in ID.
REQ-006 id_uses_rt  input  1  ID instruction reads rt as a source.
REQ-007 id_memread  input  1  ID instruction is a load; its destination is id_rt.
REQ-008 id_uses_hilo  input  1  ID instruction reads HI/LO (mfhi/mflo).
REQ-009 ex_md_start  input  1  mult/div is in EX this cycle.
REQ-010 ex_branch_taken  input  1  branch/jump resolved taken in EX this cycle.
REQ-011 pc_write  output  1  PC update enable; 0 holds the PC.
REQ-012 ifid_write  output  1  IF/ID register enable; 0 holds IF/ID.
REQ-013 ifid_flush  output  1  clears IF/ID to NOP on the next edge.
REQ-014 ctrl_sel  output  1  select for the ID/EX control mux: 0 = decoded controls (incl. ALUop), 1 = all-zero bubble.
REQ-015 md_busy  output  1  mult/div in progress.
REQ-016 stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-017 Internal tracking regs ex_memread (1b), ex_rt (5b) shall mirror the ID/EX copy: each edge, ex_memread <= id_memread & ~ctrl_sel, ex_rt <= id_rt.
REQ-018 load_use = ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))), combinational.
REQ-019 FSM states RUN and MD_BUSY with 8-bit down-counter md_cnt; md_busy = (state == MD_BUSY).
REQ-020 RUN: ex_md_start -> MD_BUSY, md_cnt <= MD_LAT-1.
REQ-021 MD_BUSY: md_cnt decrements each edge; md_cnt == 0 -> RUN; ex_md_start in MD_BUSY reloads md_cnt <= MD_LAT-1 and stays in MD_BUSY (restart wins over completion).
REQ-022 hilo_stall = id_uses_hilo & md_busy, combinational.
REQ-023 Priority, highest first: ex_branch_taken, load_use, hilo_stall.
REQ-024 ex_branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, ctrl_sel=1, no stall counted, regardless of load_use/hilo_stall.
REQ-025 Else load_use or hilo_stall: pc_write=0, ifid_write=0, ifid_flush=0, ctrl_sel=1; stall_cnt increments on that edge.
REQ-026 Else: pc_write=1, ifid_write=1, ifid_flush=0, ctrl_sel=0.
REQ-027 All five control outputs shall be combinational from registered state and current inputs (zero-cycle response); stall_cnt, md_busy, state, md_cnt, ex_* are registered.
REQ-028 A load-use stall shall last exactly one cycle: the bubble clears ex_memread on the stall edge.
REQ-029 A hilo stall shall persist every cycle md_busy=1 and release in the cycle after md_cnt reaches 0.
REQ-030 stall_cnt shall saturate at 16'hFFFF and never wrap.
REQ-031 FSM and md_cnt shall advance independently of stalls and branch flushes.

Reset
REQ-032 rst_n=0 shall immediately force state=RUN, md_cnt=0, ex_memread=0, ex_rt=0, stall_cnt=0, giving pc_write=1, ifid_write=1, ifid_flush=0, ctrl_sel=0, md_busy=0.
REQ-033 Reset asserted mid-MD_BUSY or mid-stall shall abort it; first cycle after release behaves as RUN with no hazard.

Verification
REQ-034 Load r5 in ID (id_memread=1, id_rt=5), next cycle id_rs=5 -> one cycle pc_write=0, ifid_write=0, ctrl_sel=1, stall_cnt=1; following cycle all normal.
REQ-035 Load with id_rt=0 followed by id_rs=0 -> no stall; load id_rt=7 then id_rt=7 with id_uses_rt=0 -> no stall.
REQ-036 MD_LAT=4, ex_md_start pulse, then id_uses_hilo=1 held -> md_busy=1 for 4 cycles, ctrl_sel=1 for those 4, stall_cnt=4, release on 5th.
REQ-037 load_use and ex_branch_taken in the same cycle -> ifid_flush=1, ctrl_sel=1, pc_write=1, stall_cnt unchanged.
REQ-038 ex_md_start at md_cnt=1 -> md_cnt reloads to MD_LAT-1, md_busy stays 1 for MD_LAT more cycles.
REQ-039 rst_n pulled low in MD_BUSY with hilo stall active -> outputs return to reset values asynchronously; preload stall_cnt near 16'hFFFF and hold a stall -> stays at 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard signal bundle between the ID/EX datapath and hazard_ctrl.
// The datapath (master) drives instruction fields; the controller (slave) returns stall/flush controls.
interface hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        id_memread;
  logic        id_uses_hilo;
  logic        ex_md_start;
  logic        ex_branch_taken;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        ctrl_sel;
  logic        md_busy;
  logic [15:0] stall_cnt;
  // Debug visibility of the mult/div FSM for checkers.
  logic        dbg_state;
  logic [7:0]  dbg_md_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_memread, id_uses_hilo, ex_md_start, ex_branch_taken,
    input  pc_write, ifid_write, ifid_flush, ctrl_sel, md_busy, stall_cnt, dbg_state, dbg_md_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_memread, id_uses_hilo, ex_md_start, ex_branch_taken,
    output pc_write, ifid_write, ifid_flush, ctrl_sel, md_busy, stall_cnt, dbg_state, dbg_md_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use and HI/LO stalls, taken-branch flush, mult/div busy tracking
// and a saturating stall-cycle counter. Control outputs are combinational (zero-cycle).
module hazard_ctrl #(
  parameter int MD_LAT = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} state_e;

  localparam logic [7:0] MD_RELOAD = 8'(MD_LAT - 1);

  state_e      state_q, state_d;
  logic [7:0]  md_cnt_q, md_cnt_d;
  logic        ex_memread_q, ex_memread_d;
  logic [4:0]  ex_rt_q, ex_rt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic hilo_stall;
  logic md_busy;
  logic pc_write, ifid_write, ifid_flush, ctrl_sel;
  logic stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      md_cnt_q     <= 8'd0;
      ex_memread_q <= 1'b0;
      ex_rt_q      <= 5'd0;
      stall_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      md_cnt_q     <= md_cnt_d;
      ex_memread_q <= ex_memread_d;
      ex_rt_q      <= ex_rt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // Mult/div FSM runs regardless of stalls or flushes; a restart always wins over completion.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      RUN: begin
        if (hz.ex_md_start) begin
          state_d  = MD_BUSY;
          md_cnt_d = MD_RELOAD;
        end
      end
      MD_BUSY: begin
        if (hz.ex_md_start) begin
          md_cnt_d = MD_RELOAD;
        end else if (md_cnt_q == 8'd0) begin
          state_d = RUN;
        end else begin
          md_cnt_d = md_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d  = RUN;
        md_cnt_d = 8'd0;
      end
    endcase
  end

  assign md_busy    = (state_q == MD_BUSY);
  assign load_use   = ex_memread_q && (ex_rt_q != 5'd0) &&
                      ((ex_rt_q == hz.id_rs) || (hz.id_uses_rt && (ex_rt_q == hz.id_rt)));
  assign hilo_stall = hz.id_uses_hilo && md_busy;

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    ctrl_sel   = 1'b0;
    stall      = 1'b0;
    if (hz.ex_branch_taken) begin
      ifid_flush = 1'b1;
      ctrl_sel   = 1'b1;
    end else if (load_use || hilo_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ctrl_sel   = 1'b1;
      stall      = 1'b1;
    end
  end

  // The bubble drops the load's memread, so a load-use stall lasts exactly one cycle.
  always_comb begin
    ex_memread_d = hz.id_memread && !ctrl_sel;
    ex_rt_d      = hz.id_rt;
    stall_cnt_d  = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  assign hz.pc_write   = pc_write;
  assign hz.ifid_write = ifid_write;
  assign hz.ifid_flush = ifid_flush;
  assign hz.ctrl_sel   = ctrl_sel;
  assign hz.md_busy    = md_busy;
  assign hz.stall_cnt  = stall_cnt_q;
  assign hz.dbg_state  = state_q;
  assign hz.dbg_md_cnt = md_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with MD_LAT=4.
// Control outputs are checked as {pc_write, ifid_write, ifid_flush, ctrl_sel}.
module tb_hazard_ctrl;

  localparam int MD_LAT = 4;

  localparam logic [3:0] OUT_NORM  = 4'b1100;
  localparam logic [3:0] OUT_STALL = 4'b0001;
  localparam logic [3:0] OUT_FLUSH = 4'b1111;

  logic clk;
  logic rst_n;
  int   passed;
  int   failed;
  int   total;

  hazard_ctrl_if hz ();

  hazard_ctrl #(.MD_LAT(MD_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz.slave)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {28'd0, hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.ctrl_sel};
  endfunction

  task automatic idle_inputs();
    hz.id_rs           = 5'd0;
    hz.id_rt           = 5'd0;
    hz.id_uses_rt      = 1'b0;
    hz.id_memread      = 1'b0;
    hz.id_uses_hilo    = 1'b0;
    hz.ex_md_start     = 1'b0;
    hz.ex_branch_taken = 1'b0;
  endtask

  initial begin
    passed = 0;
    failed = 0;
    total  = 0;
    idle_inputs();
    rst_n = 1'b0;
    settle();

    // Reset values
    chk("reset_outs", outs(), 32'(OUT_NORM));
    chk("reset_md_busy", 32'(hz.md_busy), 32'd0);
    chk("reset_stall_cnt", 32'(hz.stall_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Load r5 followed by a use of r5 as rs: one stall cycle
    hz.id_memread = 1'b1;
    hz.id_rt      = 5'd5;
    settle();
    chk("load_issue_outs", outs(), 32'(OUT_NORM));
    tick();
    hz.id_memread = 1'b0;
    hz.id_rt      = 5'd0;
    hz.id_rs      = 5'd5;
    settle();
    chk("load_use_outs", outs(), 32'(OUT_STALL));
    tick();
    settle();
    chk("load_use_cnt", 32'(hz.stall_cnt), 32'd1);
    chk("load_use_released", outs(), 32'(OUT_NORM));
    tick();

    // Loads to r0, and rt match without id_uses_rt, must not stall
    hz.id_rs      = 5'd0;
    hz.id_memread = 1'b1;
    hz.id_rt      = 5'd0;
    tick();
    hz.id_memread = 1'b1;
    hz.id_rt      = 5'd7;
    settle();
    chk("r0_no_stall", outs(), 32'(OUT_NORM));
    tick();
    hz.id_memread = 1'b0;
    hz.id_rt      = 5'd7;
    hz.id_uses_rt = 1'b0;
    settle();
    chk("rt_unused_no_stall", outs(), 32'(OUT_NORM));
    hz.id_uses_rt = 1'b1;
    settle();
    chk("rt_used_stall", outs(), 32'(OUT_STALL));
    hz.id_uses_rt = 1'b0;
    settle();
    tick();
    chk("rt_unused_cnt", 32'(hz.stall_cnt), 32'd1);

    // Load-use coinciding with a taken branch: flush wins, nothing counted
    hz.id_memread = 1'b1;
    hz.id_rt      = 5'd9;
    tick();
    hz.id_memread      = 1'b0;
    hz.id_rt           = 5'd0;
    hz.id_rs           = 5'd9;
    hz.ex_branch_taken = 1'b1;
    settle();
    chk("branch_over_load_use", outs(), 32'(OUT_FLUSH));
    tick();
    hz.ex_branch_taken = 1'b0;
    settle();
    chk("branch_cnt_unchanged", 32'(hz.stall_cnt), 32'd1);
    chk("branch_after_outs", outs(), 32'(OUT_NORM));
    hz.id_rs = 5'd0;

    // mult/div with a waiting mfhi: four stall cycles, release on the fifth
    hz.ex_md_start = 1'b1;
    settle();
    chk("md_start_not_busy", 32'(hz.md_busy), 32'd0);
    tick();
    hz.ex_md_start  = 1'b0;
    hz.id_uses_hilo = 1'b1;
    for (int i = 0; i < MD_LAT; i++) begin
      settle();
      chk($sformatf("hilo_busy_%0d", i), 32'(hz.md_busy), 32'd1);
      chk($sformatf("hilo_outs_%0d", i), outs(), 32'(OUT_STALL));
      chk($sformatf("hilo_md_cnt_%0d", i), 32'(hz.dbg_md_cnt), 32'(MD_LAT - 1 - i));
      tick();
    end
    settle();
    chk("hilo_release_busy", 32'(hz.md_busy), 32'd0);
    chk("hilo_release_outs", outs(), 32'(OUT_NORM));
    chk("hilo_stall_cnt", 32'(hz.stall_cnt), 32'd5);
    hz.id_uses_hilo = 1'b0;

    // Restart at md_cnt=1 reloads and keeps busy for MD_LAT more cycles
    hz.ex_md_start = 1'b1;
    tick();
    hz.ex_md_start = 1'b0;
    tick();
    tick();
    settle();
    chk("restart_pre_cnt", 32'(hz.dbg_md_cnt), 32'd1);
    hz.ex_md_start = 1'b1;
    tick();
    hz.ex_md_start = 1'b0;
    settle();
    chk("restart_reload_cnt", 32'(hz.dbg_md_cnt), 32'(MD_LAT - 1));
    for (int i = 0; i < MD_LAT; i++) begin
      settle();
      chk($sformatf("restart_busy_%0d", i), 32'(hz.md_busy), 32'd1);
      tick();
    end
    settle();
    chk("restart_done", 32'(hz.md_busy), 32'd0);
    chk("restart_no_stall_cnt", 32'(hz.stall_cnt), 32'd5);

    // Asynchronous reset in the middle of a hilo stall
    hz.ex_md_start = 1'b1;
    tick();
    hz.ex_md_start  = 1'b0;
    hz.id_uses_hilo = 1'b1;
    settle();
    chk("pre_reset_stall", outs(), 32'(OUT_STALL));
    tick();
    settle();
    chk("pre_reset_cnt", 32'(hz.stall_cnt), 32'd6);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", outs(), 32'(OUT_NORM));
    chk("async_reset_busy", 32'(hz.md_busy), 32'd0);
    chk("async_reset_cnt", 32'(hz.stall_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    settle();
    chk("post_reset_outs", outs(), 32'(OUT_NORM));
    tick();
    settle();
    chk("post_reset_busy", 32'(hz.md_busy), 32'd0);
    chk("post_reset_cnt", 32'(hz.stall_cnt), 32'd0);

    // Saturation: keep mult/div restarting with mfhi waiting
    hz.ex_md_start = 1'b1;
    tick();
    repeat (65534) tick();
    settle();
    chk("sat_near", 32'(hz.stall_cnt), 32'hFFFE);
    tick();
    settle();
    chk("sat_reach", 32'(hz.stall_cnt), 32'hFFFF);
    repeat (3) tick();
    settle();
    chk("sat_hold", 32'(hz.stall_cnt), 32'hFFFF);
    chk("sat_outs", outs(), 32'(OUT_STALL));

    // Final report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
